multi_cycle_alu: RTL and testbench

MULTI_CYCLE_ALU -- requirements
Module: multi_cycle_alu

---
 rtl/multi_cycle_alu.sv | 217 +++++++++++++++++++++
 tb/tb_multi_cycle_alu.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus an iterative
// unsigned shift-add multiplier and a restoring divider.
//
// Ports:
//   clk, reset (sync, active-low)  - clock and reset
//   start, ALUOperation, A, B      - request; sampled when not busy
//   busy                           - multi-cycle op in progress
//   done                           - one-cycle pulse, results valid
//   ALUResult, HiResult, Zero      - registered results
module multi_cycle_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUOperation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] HiResult,
    output logic             Zero
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_LUI   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_SUB   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;

    localparam int SH_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc: product high half / partial remainder
    // lo:  multiplier shifting into product low half / dividend into quotient
    // mcand: multiplicand or divisor
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic             last_iter;
    logic             b_zero;
    logic             sh_big;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [WIDTH-1:0] div_rem;

    assign accept    = start && (state_q == S_IDLE || state_q == S_DONE);
    assign last_iter = (cnt_q == LAST);
    assign b_zero    = (B == '0);
    assign sh_big    = (B >= W_LIM);

    // Single-cycle result, including out-of-range shift saturation.
    always_comb begin
        alu_out = '0;
        case (ALUOperation)
            OP_AND: alu_out = A & B;
            OP_OR:  alu_out = A | B;
            OP_NOR: alu_out = ~(A | B);
            OP_ADD: alu_out = A + B;
            OP_SUB: alu_out = A - B;
            OP_LUI: alu_out = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLL: alu_out = sh_big ? '0 : (A << B[SH_W-1:0]);
            OP_SRL: alu_out = sh_big ? '0 : (A >> B[SH_W-1:0]);
            OP_SRA: alu_out = sh_big ? {WIDTH{A[WIDTH-1]}}
                                     : $unsigned($signed(A) >>> B[SH_W-1:0]);
            default: alu_out = '0;
        endcase
    end

    // One shift-add step: add multiplicand if lsb set, shift {acc,lo} right.
    assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);

    // One restoring step; the difference fits WIDTH bits whenever it is kept.
    assign div_sh  = {acc_q, lo_q[WIDTH-1]};
    assign div_ge  = (div_sh >= {1'b0, mcand_q});
    assign div_sub = div_sh[WIDTH-1:0] - mcand_q;
    assign div_rem = div_ge ? div_sub : div_sh[WIDTH-1:0];

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (ALUOperation == OP_MULTU)
                        state_d = S_MUL;
                    else if (ALUOperation == OP_DIVU && !b_zero)
                        state_d = S_DIV;
                    else
                        state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (last_iter)
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        res_d   = res_q;
        hi_d    = hi_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (ALUOperation == OP_MULTU) begin
                        acc_d   = '0;
                        lo_d    = B;
                        mcand_d = A;
                    end else if (ALUOperation == OP_DIVU) begin
                        if (b_zero) begin
                            res_d = '1;
                            hi_d  = A;
                        end else begin
                            acc_d   = '0;
                            lo_d    = A;
                            mcand_d = B;
                        end
                    end else begin
                        res_d = alu_out;
                        hi_d  = '0;
                    end
                end
            end
            S_MUL: begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = mul_sum[WIDTH:1];
                lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
                if (last_iter) begin
                    res_d = lo_d;
                    hi_d  = acc_d;
                end
            end
            S_DIV: begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = div_rem;
                lo_d  = {lo_q[WIDTH-2:0], div_ge};
                if (last_iter) begin
                    res_d = lo_d;
                    hi_d  = acc_d;
                end
            end
            default: ;
        endcase
        zero_d = (res_d == '0);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
        end
    end

    // Outputs
    always_comb begin
        busy = (state_q == S_MUL) || (state_q == S_DIV);
        done = (state_q == S_DONE);
    end

    assign ALUResult = res_q;
    assign HiResult  = hi_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_multi_cycle_alu.sv
// Directed testbench for multi_cycle_alu (WIDTH=32).
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_multi_cycle_alu;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_LUI   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_SUB   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  ALUOperation;
    logic [31:0] A, B;
    logic        busy, done, Zero;
    logic [31:0] ALUResult, HiResult;

    int n_cmp = 0;
    int n_bad = 0;

    multi_cycle_alu #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ALUOperation(ALUOperation), .A(A), .B(B),
        .busy(busy), .done(done), .ALUResult(ALUResult),
        .HiResult(HiResult), .Zero(Zero)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and wait (bounded) for done.
    // lat = cycle index of done after the acceptance edge.
    task automatic launch(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat,
                          output int bcnt, output bit held);
        logic [31:0] prev;
        prev = ALUResult;
        start = 1'b1; ALUOperation = op; A = a; B = b;
        cyc();
        start = 1'b0;
        lat = 1; bcnt = 0; held = 1'b1;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) bcnt++;
            if (ALUResult !== prev) held = 1'b0;
            cyc();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; ALUOperation = '0; A = '0; B = '0;
        cyc(); cyc();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (ALUResult !== 32'h0) begin n_bad++; $display("FAIL rst_res: got %h want 0", ALUResult); end
        n_cmp++; if (HiResult !== 32'h0) begin n_bad++; $display("FAIL rst_hi: got %h want 0", HiResult); end
        n_cmp++; if (Zero !== 1'b1) begin n_bad++; $display("FAIL rst_zero: got %b want 1", Zero); end
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_add_wrap();
        int lat, bc; bit held;
        launch(OP_ADD, 32'hFFFF_FFFF, 32'h1, lat, bc, held);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL add_lat: got %0d want 1", lat); end
        n_cmp++; if (busy !== 1'b0 || bc !== 0) begin n_bad++; $display("FAIL add_busy: got %b/%0d want 0/0", busy, bc); end
        n_cmp++; if (ALUResult !== 32'h0) begin n_bad++; $display("FAIL add_res: got %h want 0", ALUResult); end
        n_cmp++; if (Zero !== 1'b1) begin n_bad++; $display("FAIL add_zero: got %b want 1", Zero); end
        n_cmp++; if (HiResult !== 32'h0) begin n_bad++; $display("FAIL add_hi: got %h want 0", HiResult); end
        cyc();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL add_pulse: got %b want 0", done); end
    endtask

    task automatic test_single_ops();
        logic [3:0]  ops [12] = '{OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SRL,
                                  OP_SRA, OP_SLL, OP_SLL, OP_SRL, OP_SRA,
                                  OP_LUI, 4'hF};
        logic [31:0] av [12] = '{32'd5, 32'hF0F0_FF00, 32'hF0F0_0000,
                                 32'hF0F0_0000, 32'h8000_0000,
                                 32'h8000_0000, 32'h1, 32'h1,
                                 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                                 32'hDEAD_BEEF, 32'h1234_5678};
        logic [31:0] bv [12] = '{32'd7, 32'h0FF0_F0F0, 32'h0000_000F,
                                 32'h0000_000F, 32'd4, 32'd40, 32'd31,
                                 32'd32, 32'd32, 32'd40, 32'hABCD_1234,
                                 32'h1};
        logic [31:0] ev [12] = '{32'hFFFF_FFFE, 32'h00F0_F000,
                                 32'hF0F0_000F, 32'h0F0F_FFF0,
                                 32'h0800_0000, 32'hFFFF_FFFF,
                                 32'h8000_0000, 32'h0, 32'h0, 32'h0,
                                 32'h1234_0000, 32'h0};
        int lat, bc; bit held;
        for (int i = 0; i < 12; i++) begin
            launch(ops[i], av[i], bv[i], lat, bc, held);
            n_cmp++;
            if (ALUResult !== ev[i] || HiResult !== 32'h0 || lat !== 1 ||
                Zero !== (ev[i] == 32'h0)) begin
                n_bad++;
                $display("FAIL op%0d: got res=%h hi=%h z=%b lat=%0d want res=%h hi=0 lat=1",
                         i, ALUResult, HiResult, Zero, lat, ev[i]);
            end
            cyc();
        end
    endtask

    task automatic test_multu();
        int lat, bc; bit held;
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, held);
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL mul_lat: got %0d want 33", lat); end
        n_cmp++; if (bc !== 32) begin n_bad++; $display("FAIL mul_busy: got %0d want 32", bc); end
        n_cmp++; if (!held) begin n_bad++; $display("FAIL mul_hold: got changed want held"); end
        n_cmp++; if (HiResult !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL mul_hi: got %h want fffffffe", HiResult); end
        n_cmp++; if (ALUResult !== 32'h1 || Zero !== 1'b0) begin n_bad++; $display("FAIL mul_lo: got %h z=%b want 1 z=0", ALUResult, Zero); end
        cyc();
        launch(OP_ADD, 32'd2, 32'd3, lat, bc, held);
        n_cmp++; if (HiResult !== 32'h0 || ALUResult !== 32'd5) begin n_bad++; $display("FAIL mul_then_add: got %h/%h want 0/5", HiResult, ALUResult); end
        cyc();
    endtask

    task automatic test_divu();
        int lat, bc; bit held;
        launch(OP_DIVU, 32'd100, 32'd7, lat, bc, held);
        n_cmp++; if (lat !== 33 || bc !== 32) begin n_bad++; $display("FAIL div_lat: got %0d/%0d want 33/32", lat, bc); end
        n_cmp++; if (ALUResult !== 32'd14) begin n_bad++; $display("FAIL div_q: got %0d want 14", ALUResult); end
        n_cmp++; if (HiResult !== 32'd2) begin n_bad++; $display("FAIL div_r: got %0d want 2", HiResult); end
        cyc();
        launch(OP_DIVU, 32'hFFFF_FFFF, 32'h0001_0000, lat, bc, held);
        n_cmp++; if (ALUResult !== 32'h0000_FFFF || HiResult !== 32'h0000_FFFF) begin n_bad++; $display("FAIL div_big: got %h/%h want 0000ffff/0000ffff", ALUResult, HiResult); end
        cyc();
        launch(OP_DIVU, 32'd5, 32'd0, lat, bc, held);
        n_cmp++; if (lat !== 1 || bc !== 0) begin n_bad++; $display("FAIL div0_lat: got %0d/%0d want 1/0", lat, bc); end
        n_cmp++; if (ALUResult !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div0_q: got %h want ffffffff", ALUResult); end
        n_cmp++; if (HiResult !== 32'd5) begin n_bad++; $display("FAIL div0_r: got %h want 5", HiResult); end
        cyc();
    endtask

    task automatic test_busy_ignore();
        int n;
        start = 1'b1; ALUOperation = OP_MULTU; A = 32'd3; B = 32'd5;
        cyc();
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 200) begin
            if (n == 10) begin
                start = 1'b1; ALUOperation = OP_ADD; A = 32'd1; B = 32'd1;
            end else begin
                start = 1'b0;
            end
            cyc();
            n++;
        end
        start = 1'b0;
        n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL ign_lat: got %0d want 33", n); end
        n_cmp++; if (ALUResult !== 32'd15 || HiResult !== 32'd0) begin n_bad++; $display("FAIL ign_res: got %h/%h want 15/0", ALUResult, HiResult); end
        cyc();
        n_cmp++; if (done !== 1'b0 || ALUResult !== 32'd15) begin n_bad++; $display("FAIL ign_after: got done=%b res=%h want 0/15", done, ALUResult); end
    endtask

    task automatic test_reset_abort();
        int pulses;
        start = 1'b1; ALUOperation = OP_MULTU; A = 32'd3; B = 32'd5;
        cyc();
        start = 1'b0;
        for (int i = 1; i < 5; i++) cyc();
        reset = 1'b0;
        start = 1'b1; ALUOperation = OP_ADD; A = 32'd1; B = 32'd1;
        cyc();
        reset = 1'b1; start = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL abort_ctl: got busy=%b done=%b want 0/0", busy, done); end
        n_cmp++; if (ALUResult !== 32'h0 || HiResult !== 32'h0 || Zero !== 1'b1) begin n_bad++; $display("FAIL abort_out: got %h/%h z=%b want 0/0 z=1", ALUResult, HiResult, Zero); end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1) pulses++;
            cyc();
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", pulses); end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; ALUOperation = OP_ADD; A = 32'd2; B = 32'd3;
        cyc();
        n_cmp++; if (done !== 1'b1 || ALUResult !== 32'd5) begin n_bad++; $display("FAIL b2b_first: got done=%b res=%h want 1/5", done, ALUResult); end
        ALUOperation = OP_SUB; A = 32'd10; B = 32'd4;
        cyc();
        start = 1'b0;
        n_cmp++; if (done !== 1'b1 || ALUResult !== 32'd6) begin n_bad++; $display("FAIL b2b_second: got done=%b res=%h want 1/6", done, ALUResult); end
        cyc();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got %b want 0", done); end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_single_ops();
        test_multu();
        test_divu();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
